pmu_stream_tx: RTL
==================

Name: pmu_stream_tx

Overview:
- Transmit-side counterpart of the PMU JTAG bitstream loader. Serialises a secured bitstream onto the PMU tms/tdi pins.
- Frame layout, in order: JTAG entry header, 256-bit PMU header, 256-bit header digest, C pairs of (256-bit chunk, 256-bit chunk digest), JTAG exit footer.
- Sits on the SoC side. Payload is pulled as 32-bit words from a host FIFO. The PMU tck is derived from clk_i gated by tck_en_o.

Parameters:
- WORD_W, 32, payload input word width; must divide BLOCK_W.
- BLOCK_W, 256, bits per header, digest or chunk block.
- CNT_W, 16, width of the chunk-count input.

Ports:
- clk_i  in  1  system clock; PMU tck is clk_i gated by tck_en_o.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle pulse that starts a frame; accepted only in IDLE.
- chunk_cnt_i  in  CNT_W  number C of chunk/digest pairs; sampled on an accepted start_i.
- word_i  in  WORD_W  payload word; bit 0 is transmitted first.
- word_valid_i  in  1  word_i is valid.
- word_ready_o  out  1  word is consumed on a cycle where word_valid_i and word_ready_o are both 1.
- tms_o  out  1  JTAG TMS toward the PMU.
- tdi_o  out  1  JTAG TDI toward the PMU.
- tck_en_o  out  1  tms_o/tdi_o are presented on this cycle and the PMU must be clocked.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse after the final gap cycle.
- underrun_o  out  1  sticky flag: payload stalled at least once in this frame; cleared on an accepted start_i.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE; all counters 0; input buffer empty. Outputs tms_o=0, tdi_o=0, tck_en_o=0, word_ready_o=0, busy_o=0, done_o=0, underrun_o=0. Reset mid-frame abandons the frame immediately; no footer is sent.
- State sequence: IDLE -> HDR -> PAY -> FTR -> GAP -> IDLE.
- IDLE:
  - start_i=1 latches chunk_cnt_i, computes blocks = 2 + 2*C, clears underrun_o, sets busy_o=1 and enters HDR.
  - start_i in any other state is ignored.
- HDR: 12 cycles, tck_en_o=1, bit k on cycle k (k=0..11).
  - tms_o = 12'b011000000110[k]; tdi_o = 12'b001101100000[k]; index 0 is the LSB.
  - The first header bit appears the cycle after start_i is accepted.
- PAY: blocks*BLOCK_W bits with tms_o=0; tdi_o = current bit of the 32-bit shift register, LSB first.
  - Block and word boundaries are seamless; no gaps are inserted.
  - Buffering is two stages: the shift register plus one prefetch word register.
  - word_ready_o=1 whenever the prefetch register is empty and payload words are still owed. Words owed = blocks*BLOCK_W/WORD_W minus words accepted.
  - Prefetch starts in HDR, so a source with zero wait states never stalls.
  - Stall: if the shift register is exhausted and the prefetch register is empty, then tck_en_o=0, tms_o/tdi_o hold their last values, and underrun_o is set. Transmission resumes on the cycle after a word is accepted.
  - Simultaneous accept and shift-register reload in the same cycle is legal; it must neither lose nor duplicate a word.
- FTR: 5 cycles, tck_en_o=1, tms_o=1, tdi_o=0.
- GAP: 1 cycle, tck_en_o=1, tms_o=0, tdi_o=0.
- GAP -> IDLE: at that edge busy_o falls and done_o pulses for one cycle.
- Counters:
  - bit-in-word counter: 0..WORD_W-1, wraps to 0.
  - word counter: width ceil(log2(words/block)).
  - block counter: CNT_W+2 bits; no overflow at C=2^CNT_W-1.
- C=0 is legal: sends header block and header digest only (2 blocks).
- Unstalled frame length in tck_en_o cycles = 12 + 512*(1+C) + 5 + 1.

Decomposition:
- Package pmu_stream_pkg holds:
  - JTAG_TMS_HDR = 12'b011000000110 and JTAG_TDI_HDR = 12'b001101100000.
  - FTR_LEN = 5 and HDR_LEN = 12.
  - The state enum: IDLE, HDR, PAY, FTR, GAP.
- One sub-module, pmu_stream_piso: the 32-bit prefetch register plus parallel-in/serial-out shift register. It exposes load/ready/shift/empty and owns the stall logic.
- The top module holds the FSM and the block/word counters.

Test Plan:
- C=3, source always valid, payload words taken from pmu_header0, header_digest0, then 3×(bitstream0, digest0) word by word -> exactly 2066 tck_en_o cycles; tdi/tms trace equals the PMU-loader stimulus sequence bit for bit; underrun_o=0; done_o pulses once.
- C=0 -> 12+512+6 = 530 enabled cycles; exactly 16 words consumed; footer tms=11111.
- C=3 with word_valid_i deasserted for 40 cycles at word 20 -> tck_en_o=0 for the stall span; underrun_o=1; serialised bit sequence identical to the unstalled run.
- rst_i asserted during block 2 bit 100 -> next-cycle outputs all 0, state IDLE; a new start_i with C=1 produces a clean 1042-cycle frame.
- start_i pulsed during PAY with chunk_cnt_i=7 -> ignored; frame length unchanged; no word over-consumption.
- Back-to-back: start_i in the cycle after done_o -> HDR bit 0 appears on the following cycle; header bits 0..11 checked against both constants.

Source files
------------

// File: rtl/pmu_stream_pkg.sv
// Shared constants and state encoding for the PMU bitstream transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pmu_stream_pkg;

    // JTAG entry sequence, bit k is driven on header cycle k (LSB first)
    localparam logic [11:0] JTAG_TMS_HDR = 12'b011000000110;
    localparam logic [11:0] JTAG_TDI_HDR = 12'b001101100000;

    localparam int HDR_LEN = 12;
    localparam int FTR_LEN = 5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        FTR,
        GAP
    } state_t;

endpackage

// File: rtl/pmu_stream_tx_if.sv
// Host-side payload stream plus PMU pin bundle of the bitstream transmitter.
// Latency: n/a (wiring only).
// Backpressure: word_ready_o qualifies word_valid_i; start_i is a one-cycle pulse.
interface pmu_stream_tx_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
);
    logic              start_i;
    logic [CNT_W-1:0]  chunk_cnt_i;
    logic [WORD_W-1:0] word_i;
    logic              word_valid_i;
    logic              word_ready_o;
    logic              tms_o;
    logic              tdi_o;
    logic              tck_en_o;
    logic              busy_o;
    logic              done_o;
    logic              underrun_o;

    // host / controller side
    modport master (
        output start_i, chunk_cnt_i, word_i, word_valid_i,
        input  word_ready_o, tms_o, tdi_o, tck_en_o, busy_o, done_o, underrun_o
    );

    // transmitter side
    modport slave (
        input  start_i, chunk_cnt_i, word_i, word_valid_i,
        output word_ready_o, tms_o, tdi_o, tck_en_o, busy_o, done_o, underrun_o
    );
endinterface

// File: rtl/pmu_stream_piso.sv
// Prefetch word register feeding a parallel-in/serial-out shift register, LSB first.
// Latency: a word accepted while both stages are empty is on ser_dat in the same cycle.
// Backpressure: ready while the prefetch register is empty; empty flags a stall.
module pmu_stream_piso #(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic [WORD_W-1:0] load_dat,
    input  logic              shift,
    output logic              ready,
    output logic              empty,
    output logic              ser_dat,
    output logic              last_bit
);
    localparam int CW = $clog2(WORD_W);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] pf_q;
    logic              sr_vld;
    logic              pf_vld;
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] head;

    assign ready    = !pf_vld;
    assign empty    = !sr_vld && !pf_vld && !load;
    assign last_bit = sr_vld && (bit_cnt == CW'(WORD_W - 1));
    assign ser_dat  = head[0];

    // Oldest available word: shift register, else prefetch, else the word arriving now
    always_comb begin
        head = load_dat;
        if (sr_vld) begin
            head = sr_q;
        end else if (pf_vld) begin
            head = pf_q;
        end
    end

    // Shift/reload: a word whose last bit goes out is replaced in the same edge so
    // consecutive words stream without a gap; an accept never overwrites a full prefetch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            pf_q    <= '0;
            sr_vld  <= 1'b0;
            pf_vld  <= 1'b0;
            bit_cnt <= '0;
        end else if (shift && !empty) begin
            if (!sr_vld) begin
                // bit 0 of head leaves now; prefetch (or the bypassed word) moves down
                sr_q    <= head >> 1;
                sr_vld  <= 1'b1;
                bit_cnt <= CW'(1);
                pf_vld  <= 1'b0;
            end else if (last_bit) begin
                bit_cnt <= '0;
                if (pf_vld) begin
                    sr_q   <= pf_q;
                    pf_vld <= 1'b0;
                end else if (load) begin
                    sr_q <= load_dat;
                end else begin
                    sr_vld <= 1'b0;
                end
            end else begin
                sr_q    <= sr_q >> 1;
                bit_cnt <= bit_cnt + CW'(1);
                if (load) begin
                    pf_q   <= load_dat;
                    pf_vld <= 1'b1;
                end
            end
        end else if (load) begin
            pf_q   <= load_dat;
            pf_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/pmu_stream_tx.sv
// Serialises header, (2+2C) payload blocks and footer onto the PMU tms/tdi pins.
// Latency: first header bit on the cycle after start_i; all pin outputs registered.
// Backpressure: pulls words via valid/ready; an empty buffer stalls tck_en_o and sets underrun_o.
module pmu_stream_tx #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 256,
    parameter int CNT_W   = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pmu_stream_tx_if.slave bus
);
    import pmu_stream_pkg::*;

    localparam int WPB   = BLOCK_W / WORD_W;
    localparam int WPB_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BLK_W = CNT_W + 2;
    localparam int OWE_W = BLK_W + WPB_W;

    state_t             state;
    logic [3:0]         hdr_cnt;
    logic [2:0]         ftr_cnt;
    logic [WPB_W-1:0]   word_cnt;
    logic [BLK_W-1:0]   blk_cnt;
    logic [BLK_W-1:0]   blocks;
    logic [BLK_W-1:0]   blocks_nxt;
    logic [OWE_W-1:0]   owed;
    logic               pay_last;
    logic               tms_q;
    logic               tdi_q;
    logic               tck_en_q;
    logic               busy_q;
    logic               done_q;
    logic               underrun_q;

    logic word_rdy;
    logic ld;
    logic shift_req;
    logic shift_fire;
    logic piso_rdy;
    logic piso_empty;
    logic ser_dat;
    logic last_bit;

    assign blocks_nxt = BLK_W'({bus.chunk_cnt_i, 1'b0}) + BLK_W'(2);

    // prefetch runs from the first header cycle so a zero-wait source never stalls
    assign word_rdy   = ((state == HDR) || (state == PAY)) && (owed != '0) && piso_rdy;
    assign ld         = bus.word_valid_i && word_rdy;
    assign shift_req  = ((state == HDR) && (hdr_cnt == 4'(HDR_LEN - 1)))
                      || ((state == PAY) && !pay_last);
    assign shift_fire = shift_req && !piso_empty;

    pmu_stream_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (ld),
        .load_dat (bus.word_i),
        .shift    (shift_req),
        .ready    (piso_rdy),
        .empty    (piso_empty),
        .ser_dat  (ser_dat),
        .last_bit (last_bit)
    );

    // Frame FSM: every register holds what the pins show in the following cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            hdr_cnt    <= '0;
            ftr_cnt    <= '0;
            word_cnt   <= '0;
            blk_cnt    <= '0;
            blocks     <= '0;
            owed       <= '0;
            pay_last   <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
            tck_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld) begin
                owed <= owed - OWE_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state      <= HDR;
                        blocks     <= blocks_nxt;
                        owed       <= OWE_W'(blocks_nxt) * OWE_W'(WPB);
                        hdr_cnt    <= '0;
                        word_cnt   <= '0;
                        blk_cnt    <= '0;
                        pay_last   <= 1'b0;
                        underrun_q <= 1'b0;
                        busy_q     <= 1'b1;
                        tck_en_q   <= 1'b1;
                        tms_q      <= JTAG_TMS_HDR[0];
                        tdi_q      <= JTAG_TDI_HDR[0];
                    end
                end
                HDR: begin
                    if (hdr_cnt == 4'(HDR_LEN - 1)) begin
                        // pins for the first payload cycle are set by the shift logic below
                        state <= PAY;
                    end else begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        tms_q   <= JTAG_TMS_HDR[hdr_cnt + 4'd1];
                        tdi_q   <= JTAG_TDI_HDR[hdr_cnt + 4'd1];
                    end
                end
                PAY: begin
                    if (pay_last) begin
                        state    <= FTR;
                        ftr_cnt  <= '0;
                        tms_q    <= 1'b1;
                        tdi_q    <= 1'b0;
                        tck_en_q <= 1'b1;
                    end
                end
                FTR: begin
                    if (ftr_cnt == 3'(FTR_LEN - 1)) begin
                        state <= GAP;
                        tms_q <= 1'b0;
                        tdi_q <= 1'b0;
                    end else begin
                        ftr_cnt <= ftr_cnt + 3'd1;
                    end
                end
                GAP: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    tck_en_q <= 1'b0;
                    tms_q    <= 1'b0;
                    tdi_q    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Payload bit step; a stall freezes tms/tdi and only drops the clock enable
            if (shift_fire) begin
                tms_q    <= 1'b0;
                tdi_q    <= ser_dat;
                tck_en_q <= 1'b1;
                if (last_bit) begin
                    if (word_cnt == WPB_W'(WPB - 1)) begin
                        word_cnt <= '0;
                        if (blk_cnt == blocks - BLK_W'(1)) begin
                            pay_last <= 1'b1;
                        end else begin
                            blk_cnt <= blk_cnt + BLK_W'(1);
                        end
                    end else begin
                        word_cnt <= word_cnt + WPB_W'(1);
                    end
                end
            end else if (shift_req) begin
                tck_en_q   <= 1'b0;
                underrun_q <= 1'b1;
            end
        end
    end

    assign bus.word_ready_o = word_rdy;
    assign bus.tms_o        = tms_q;
    assign bus.tdi_o        = tdi_q;
    assign bus.tck_en_o     = tck_en_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.underrun_o   = underrun_q;

endmodule
